// File: rtl/btb_pkg.sv
// Shared types for the BTB update sequencer.
// Holds the sweep FSM encoding and the two queued-request bundles.
package btb_pkg;

    localparam int BTB_IDX_W = 8;
    localparam int BTB_WAYS  = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } btb_ctl_state_e;

    typedef struct packed {
        logic [2:0]  brpos;
        logic [1:0]  brtyp;
        logic [1:0]  rasctl;
        logic [63:0] brpc;
        logic [63:0] brtar;
    } btb_sp_ent_t;

    typedef struct packed {
        logic        brdir;
        logic [63:0] brpc;
    } btb_rt_ent_t;

endpackage

// File: rtl/btb_upd_ctrl_if.sv
// Request-side handshakes into the BTB update sequencer.
// master: fetch1 allocate / retire update sources; slave: sequencer.
interface btb_upd_ctrl_if;

    logic        sp_req;
    logic [2:0]  sp_brpos;
    logic [1:0]  sp_brtyp;
    logic [1:0]  sp_rasctl;
    logic [63:0] sp_brpc;
    logic [63:0] sp_brtar;
    logic        sp_rdy;

    logic        rt_req;
    logic        rt_brdir;
    logic [63:0] rt_brpc;
    logic        rt_rdy;

    modport master (
        output sp_req, sp_brpos, sp_brtyp, sp_rasctl,
        output sp_brpc, sp_brtar,
        input  sp_rdy,
        output rt_req, rt_brdir, rt_brpc,
        input  rt_rdy
    );

    modport slave (
        input  sp_req, sp_brpos, sp_brtyp, sp_rasctl,
        input  sp_brpc, sp_brtar,
        output sp_rdy,
        input  rt_req, rt_brdir, rt_brpc,
        output rt_rdy
    );

endinterface

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO with clear and in-place tail overwrite.
// Caller guarantees no pop when empty and no push when full.
module btb_upd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         ovw_i,
    input  logic [W-1:0] ovw_data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic         single_o,
    output logic [W-1:0] head_o,
    output logic [W-1:0] tail_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] tp;
    logic [CW-1:0] cnt_q, cnt_d;

    assign tp       = wp_q - AW'(1);
    assign full_o   = cnt_q == CW'(DEPTH);
    assign empty_o  = cnt_q == '0;
    assign single_o = cnt_q == CW'(1);
    assign head_o   = mem_q[rp_q];
    assign tail_o   = mem_q[tp];

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wp_d = wp_q + AW'(1);
            if (pop_i)  rp_d = rp_q + AW'(1);
            if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
            if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push_i && !clr_i) mem_q[wp_q] <= push_data_i;
        if (ovw_i && !clr_i)  mem_q[tp]   <= ovw_data_i;
    end

endmodule

// File: rtl/btb_upd_ctrl.sv
// BTB update sequencer: queues allocate and retire updates, orders them
// per PC, and sweeps the whole array invalid after reset or flush.
module btb_upd_ctrl
    import btb_pkg::*;
#(
    parameter int SP_DEPTH = 4,
    parameter int RT_DEPTH = 4,
    parameter int IDX_W    = BTB_IDX_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_i,
    btb_upd_ctrl_if.slave    req_if,
    output logic             btb_sp_we_o,
    output logic [2:0]       btb_sp_brpos_o,
    output logic [1:0]       btb_sp_brtyp_o,
    output logic [1:0]       btb_sp_rasctl_o,
    output logic [63:0]      btb_sp_brpc_o,
    output logic [63:0]      btb_sp_brtar_o,
    output logic             btb_rt_we_o,
    output logic             btb_rt_brdir_o,
    output logic [63:0]      btb_rt_brpc_o,
    output logic             btb_inv_we_o,
    output logic [IDX_W-1:0] btb_inv_idx_o,
    output logic             btb_rd_block_o,
    output logic             busy_o
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    btb_ctl_state_e   state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] inv_idx_q, inv_idx_d;
    logic             inv_we_q, inv_we_d;

    btb_sp_ent_t sp_in, sp_head, sp_tail, sp_out_q;
    btb_rt_ent_t rt_in, rt_head, rt_tail_unused, rt_out_q;
    logic        sp_we_q, rt_we_q;
    logic        sp_full, sp_empty, sp_single;
    logic        rt_full, rt_empty, rt_single_unused;
    logic        run, go, hazard, coal;
    logic        sp_pop, rt_pop, sp_acc, rt_acc;

    assign run = state_q == RUN;
    assign go  = run & ~flush_i;

    assign sp_in = '{
        brpos:  req_if.sp_brpos,
        brtyp:  req_if.sp_brtyp,
        rasctl: req_if.sp_rasctl,
        brpc:   req_if.sp_brpc,
        brtar:  req_if.sp_brtar
    };
    assign rt_in = '{brdir: req_if.rt_brdir, brpc: req_if.rt_brpc};

    // Retire update waits while its allocation is still ahead of it.
    assign hazard = ~sp_empty & ~rt_empty
                  & (sp_head.brpc == rt_head.brpc);
    assign sp_pop = go & ~sp_empty;
    assign rt_pop = go & ~rt_empty & ~hazard;

    assign coal = ~sp_empty
                & (req_if.sp_brpc == sp_tail.brpc)
                & ~(sp_pop & sp_single);

    assign req_if.sp_rdy = go & (~sp_full | coal);
    assign req_if.rt_rdy = go & ~rt_full;
    assign sp_acc = req_if.sp_req & req_if.sp_rdy;
    assign rt_acc = req_if.rt_req & req_if.rt_rdy;

    btb_upd_fifo #(
        .W     ($bits(btb_sp_ent_t)),
        .DEPTH (SP_DEPTH)
    ) u_sp_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .clr_i       (flush_i),
        .push_i      (sp_acc & ~coal),
        .push_data_i (sp_in),
        .pop_i       (sp_pop),
        .ovw_i       (sp_acc & coal),
        .ovw_data_i  (sp_in),
        .full_o      (sp_full),
        .empty_o     (sp_empty),
        .single_o    (sp_single),
        .head_o      (sp_head),
        .tail_o      (sp_tail)
    );

    btb_upd_fifo #(
        .W     ($bits(btb_rt_ent_t)),
        .DEPTH (RT_DEPTH)
    ) u_rt_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .clr_i       (flush_i),
        .push_i      (rt_acc),
        .push_data_i (rt_in),
        .pop_i       (rt_pop),
        .ovw_i       (1'b0),
        .ovw_data_i  ('0),
        .full_o      (rt_full),
        .empty_o     (rt_empty),
        .single_o    (rt_single_unused),
        .head_o      (rt_head),
        .tail_o      (rt_tail_unused)
    );

    // Sweep ends once the last set index is visible on the port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inv_we_d  = 1'b0;
        inv_idx_d = inv_idx_q;
        unique case (state_q)
            INIT: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else if (inv_we_q && inv_idx_q == IDX_MAX) begin
                    state_d = RUN;
                end else begin
                    inv_we_d  = 1'b1;
                    inv_idx_d = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            inv_we_q  <= 1'b0;
            inv_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inv_we_q  <= inv_we_d;
            inv_idx_q <= inv_idx_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_we_q  <= 1'b0;
            rt_we_q  <= 1'b0;
            sp_out_q <= '0;
            rt_out_q <= '0;
        end else begin
            sp_we_q <= sp_pop;
            rt_we_q <= rt_pop;
            if (sp_pop) sp_out_q <= sp_head;
            if (rt_pop) rt_out_q <= rt_head;
        end
    end

    assign btb_sp_we_o     = sp_we_q;
    assign btb_sp_brpos_o  = sp_out_q.brpos;
    assign btb_sp_brtyp_o  = sp_out_q.brtyp;
    assign btb_sp_rasctl_o = sp_out_q.rasctl;
    assign btb_sp_brpc_o   = sp_out_q.brpc;
    assign btb_sp_brtar_o  = sp_out_q.brtar;
    assign btb_rt_we_o     = rt_we_q;
    assign btb_rt_brdir_o  = rt_out_q.brdir;
    assign btb_rt_brpc_o   = rt_out_q.brpc;
    assign btb_inv_we_o    = inv_we_q;
    assign btb_inv_idx_o   = inv_idx_q;
    assign btb_rd_block_o  = ~run;
    assign busy_o = ~run | ~sp_empty | ~rt_empty | sp_we_q | rt_we_q;

endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Scoreboard bench for btb_upd_ctrl: queue-level reference model,
// randomized traffic, directed sweep/flush/reset/ordering cases.
module tb_btb_upd_ctrl;
  import btb_pkg::*;

  localparam int SPD  = 4;
  localparam int RTD  = 4;
  localparam int IW   = 8;
  localparam int NSET = 1 << IW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush_i = 1'b0;
  logic          btb_sp_we_o;
  logic [2:0]    btb_sp_brpos_o;
  logic [1:0]    btb_sp_brtyp_o;
  logic [1:0]    btb_sp_rasctl_o;
  logic [63:0]   btb_sp_brpc_o;
  logic [63:0]   btb_sp_brtar_o;
  logic          btb_rt_we_o;
  logic          btb_rt_brdir_o;
  logic [63:0]   btb_rt_brpc_o;
  logic          btb_inv_we_o;
  logic [IW-1:0] btb_inv_idx_o;
  logic          btb_rd_block_o;
  logic          busy_o;

  btb_upd_ctrl_if req_if();

  btb_upd_ctrl #(
    .SP_DEPTH (SPD),
    .RT_DEPTH (RTD),
    .IDX_W    (IW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush_i         (flush_i),
    .req_if          (req_if),
    .btb_sp_we_o     (btb_sp_we_o),
    .btb_sp_brpos_o  (btb_sp_brpos_o),
    .btb_sp_brtyp_o  (btb_sp_brtyp_o),
    .btb_sp_rasctl_o (btb_sp_rasctl_o),
    .btb_sp_brpc_o   (btb_sp_brpc_o),
    .btb_sp_brtar_o  (btb_sp_brtar_o),
    .btb_rt_we_o     (btb_rt_we_o),
    .btb_rt_brdir_o  (btb_rt_brdir_o),
    .btb_rt_brpc_o   (btb_rt_brpc_o),
    .btb_inv_we_o    (btb_inv_we_o),
    .btb_inv_idx_o   (btb_inv_idx_o),
    .btb_rd_block_o  (btb_rd_block_o),
    .busy_o          (busy_o)
  );

  always #5 clock = ~clock;

  typedef struct { int c; btb_sp_ent_t e; } sp_exp_t;
  typedef struct { int c; btb_rt_ent_t e; } rt_exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  sp_exp_t exp_sp[$];
  rt_exp_t exp_rt[$];
  btb_sp_ent_t msp[$];
  btb_rt_ent_t mrt[$];
  int s = 0;
  bit m_spwe = 0;
  bit m_rtwe = 0;
  logic [63:0] pcs [4] = '{64'h1000, 64'h2000, 64'h3000, 64'h4000};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string n, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", n, a, e, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a write strobe appears.
  initial forever begin
    sp_exp_t se;
    rt_exp_t re;
    @(negedge clock);
    if (reset_n) begin
      if (btb_sp_we_o) begin
        if (exp_sp.size() == 0) chk("sp_we_unexp", 1, 0);
        else begin
          se = exp_sp.pop_front();
          chk("sp_cyc", cyc, se.c);
          chk("sp_ent", {btb_sp_brpos_o, btb_sp_brtyp_o,
                         btb_sp_rasctl_o, btb_sp_brpc_o,
                         btb_sp_brtar_o}, se.e);
        end
      end else if (exp_sp.size() > 0 && exp_sp[0].c <= cyc) begin
        chk("sp_we_miss", 0, 1);
        void'(exp_sp.pop_front());
      end
      if (btb_rt_we_o) begin
        if (exp_rt.size() == 0) chk("rt_we_unexp", 1, 0);
        else begin
          re = exp_rt.pop_front();
          chk("rt_cyc", cyc, re.c);
          chk("rt_ent", {btb_rt_brdir_o, btb_rt_brpc_o}, re.e);
        end
      end else if (exp_rt.size() > 0 && exp_rt[0].c <= cyc) begin
        chk("rt_we_miss", 0, 1);
        void'(exp_rt.pop_front());
      end
    end
  end

  // Reference model: one call per cycle, evaluated mid-cycle.
  task automatic model();
    bit run, inv_e, busy_e, sp_pop, rt_pop, coal, haz;
    bit sp_rdy_e, rt_rdy_e;
    btb_sp_ent_t ent;
    btb_rt_ent_t rent;
    run   = s >= NSET + 1;
    inv_e = s >= 1 && s <= NSET;
    chk("rd_block", btb_rd_block_o, !run);
    chk("inv_we", btb_inv_we_o, inv_e);
    if (inv_e) chk("inv_idx", btb_inv_idx_o, s - 1);
    busy_e = !run || msp.size() > 0 || mrt.size() > 0
             || m_spwe || m_rtwe;
    chk("busy", busy_o, busy_e);
    sp_pop = run && !flush_i && msp.size() > 0;
    coal = msp.size() > 0 && msp[$].brpc == req_if.sp_brpc
           && !(sp_pop && msp.size() == 1);
    sp_rdy_e = run && !flush_i && (msp.size() < SPD || coal);
    rt_rdy_e = run && !flush_i && mrt.size() < RTD;
    chk("sp_rdy", req_if.sp_rdy, sp_rdy_e);
    chk("rt_rdy", req_if.rt_rdy, rt_rdy_e);
    haz = msp.size() > 0 && mrt.size() > 0
          && msp[0].brpc == mrt[0].brpc;
    rt_pop = run && !flush_i && mrt.size() > 0 && !haz;
    m_spwe = sp_pop;
    m_rtwe = rt_pop;
    if (sp_pop) begin
      ent = msp.pop_front();
      exp_sp.push_back('{c: cyc + 1, e: ent});
    end
    if (rt_pop) begin
      rent = mrt.pop_front();
      exp_rt.push_back('{c: cyc + 1, e: rent});
    end
    if (req_if.sp_req && sp_rdy_e) begin
      ent = '{brpos: req_if.sp_brpos, brtyp: req_if.sp_brtyp,
              rasctl: req_if.sp_rasctl, brpc: req_if.sp_brpc,
              brtar: req_if.sp_brtar};
      if (coal) msp[$] = ent;
      else msp.push_back(ent);
    end
    if (req_if.rt_req && rt_rdy_e) begin
      rent = '{brdir: req_if.rt_brdir, brpc: req_if.rt_brpc};
      mrt.push_back(rent);
    end
    if (flush_i) begin
      msp.delete();
      mrt.delete();
      s = 0;
    end else begin
      s++;
    end
  endtask

  task automatic step();
    @(negedge clock);
    model();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_if.sp_req    = 1'b0;
    req_if.sp_brpos  = '0;
    req_if.sp_brtyp  = '0;
    req_if.sp_rasctl = '0;
    req_if.sp_brpc   = '0;
    req_if.sp_brtar  = '0;
    req_if.rt_req    = 1'b0;
    req_if.rt_brdir  = 1'b0;
    req_if.rt_brpc   = '0;
    flush_i          = 1'b0;
  endtask

  task automatic drive_rand(int psp, int prt);
    req_if.sp_req    = $urandom_range(99) < psp;
    req_if.sp_brpos  = 3'($urandom);
    req_if.sp_brtyp  = 2'($urandom);
    req_if.sp_rasctl = 2'($urandom);
    req_if.sp_brpc   = pcs[$urandom_range(3)];
    req_if.sp_brtar  = {$urandom, $urandom};
    req_if.rt_req    = $urandom_range(99) < prt;
    req_if.rt_brdir  = 1'($urandom);
    req_if.rt_brpc   = pcs[$urandom_range(3)];
    flush_i          = 1'b0;
  endtask

  task automatic sp_only(logic [63:0] pc, logic [63:0] tar);
    idle();
    req_if.sp_req    = 1'b1;
    req_if.sp_brpos  = 3'd5;
    req_if.sp_brtyp  = 2'd2;
    req_if.sp_rasctl = 2'd1;
    req_if.sp_brpc   = pc;
    req_if.sp_brtar  = tar;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_inv_we", btb_inv_we_o, 0);
    chk("rst_inv_idx", btb_inv_idx_o, 0);
    chk("rst_sp_we", btb_sp_we_o, 0);
    chk("rst_rt_we", btb_rt_we_o, 0);
    chk("rst_sp_data", {btb_sp_brpos_o, btb_sp_brtyp_o,
                        btb_sp_rasctl_o, btb_sp_brpc_o,
                        btb_sp_brtar_o}, 0);
    chk("rst_rt_data", {btb_rt_brdir_o, btb_rt_brpc_o}, 0);
    chk("rst_rd_block", btb_rd_block_o, 1);
    chk("rst_busy", busy_o, 1);
    chk("rst_sp_rdy", req_if.sp_rdy, 0);
    chk("rst_rt_rdy", req_if.rt_rdy, 0);
    msp.delete();
    mrt.delete();
    exp_sp.delete();
    exp_rt.delete();
    m_spwe = 0;
    m_rtwe = 0;
    s = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #1;
    do_reset();
    while (s < NSET + 1) begin drive_rand(50, 50); step(); end
    idle();
    repeat (3) step();
    sp_only(64'h1000, 64'h2000);
    step();
    idle();
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      sp_only(64'h5000 + 64'(i * 16), 64'h9000 + 64'(i));
      step();
    end
    idle();
    repeat (4) step();
    sp_only(64'h3000, 64'h7000);
    req_if.rt_req   = 1'b1;
    req_if.rt_brdir = 1'b1;
    req_if.rt_brpc  = 64'h3000;
    step();
    idle();
    repeat (4) step();
    repeat (400) begin drive_rand(70, 70); step(); end
    repeat (3) begin drive_rand(100, 100); step(); end
    drive_rand(100, 100);
    flush_i = 1'b1;
    step();
    idle();
    while (s < NSET + 1) begin drive_rand(40, 40); step(); end
    repeat (100) begin drive_rand(60, 60); step(); end
    idle();
    flush_i = 1'b1;
    step();
    while (s < 50) begin drive_rand(30, 30); step(); end
    drive_rand(30, 30);
    flush_i = 1'b1;
    step();
    while (s < 101) begin drive_rand(30, 30); step(); end
    idle();
    do_reset();
    while (s < NSET + 1) begin drive_rand(30, 30); step(); end
    repeat (100) begin drive_rand(60, 60); step(); end
    idle();
    repeat (8) step();
    chk("drain", exp_sp.size() + exp_rt.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
